dcollide_spheres_fx: RTL and testbench

- Parametrised fixed-point successor to the float sphere-sphere collision unit. Takes two spheres (centre, radius) over a valid/ready handshake.
- Returns contact flag, contact position, unit normal (p1-p2)/d and penetration depth, all in signed fixed point.
- Replaces float conversion and approximate sqrt with an exact iterative integer sqrt and a reciprocal divider.
- Adds an optional early exit for non-colliding pairs and a constant-latency mode.

---
 rtl/dcollide_spheres_fx.sv | 232 +++++++++++++++++++++++
 tb/tb_dcollide_spheres_fx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dcollide_spheres_fx.sv
// Fixed-point sphere-sphere collision unit: one request in flight, exact
// restoring isqrt for the centre distance and a restoring reciprocal divider
// for the normal. Optional early exit for separated pairs.
module dcollide_spheres_fx #(
  parameter int W          = 32,
  parameter int FRAC       = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] z1,
  input  logic [W-1:0] r1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] y2,
  input  logic [W-1:0] z2,
  input  logic [W-1:0] r2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         ret,
  output logic [W-1:0] cx,
  output logic [W-1:0] cy,
  output logic [W-1:0] cz,
  output logic [W-1:0] normalx,
  output logic [W-1:0] normaly,
  output logic [W-1:0] normalz,
  output logic [W-1:0] depth
);
  localparam int DW = 2*W+4;             // squared distance
  localparam int PW = 2*W+2;             // products / squared radius sum
  localparam int RW = W+4;               // sqrt partial remainder
  localparam int CW = $clog2(W+2);
  localparam logic [W-1:0]   SMAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   ONE    = {{(W-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [2*W-1:0] NUM    = {{(2*W-1){1'b0}}, 1'b1} << (2*FRAC);
  localparam logic [2*W-1:0] NUM_HI = NUM >> W;   // nonzero part above the W quotient bits

  typedef enum logic [2:0] {IDLE, CALC, SQR, CMP, SQRT, DIV, MUL, DONE} st_t;
  st_t st_q, st_d;

  logic signed [W:0]    dif_q [3];
  logic signed [W:0]    rsum_q;
  logic [W-1:0]         p1_q [3];
  logic [W-1:0]         r1_q, r2_q;
  logic signed [DW-1:0] d2_q;
  logic signed [PW-1:0] rs2_q;
  logic                 hit_q;
  logic [CW-1:0]        cnt_q;
  logic [RW-1:0]        srem_q;
  logic [W:0]           root_q;
  logic [W-1:0]         d_q;
  logic [W:0]           drem_q;
  logic [W-1:0]         quo_q, nsh_q;
  logic                 ret_q;
  logic [W-1:0]         c_q [3];
  logic [W-1:0]         n_q [3];
  logic [W-1:0]         dep_q;

  logic signed [DW-1:0] d2_d, ea, rs2_x;
  logic signed [PW-1:0] rs2_d, er, a, b, pn, en, ek, pc;
  logic                 hit_d;
  logic [RW-1:0]        rem_sh, trial, rem_nx;
  logic [W:0]           root_nx;
  logic [W-1:0]         root_sat;
  logic [W:0]           drem_sh, drem_nx, d_ext;
  logic [W-1:0]         quo_nx, inv;
  logic                 ovf;
  logic signed [W+1:0]  kx, kk;
  logic [W-1:0]         nrm_d [3];
  logic [W-1:0]         cpos_d [3];
  logic [W-1:0]         dep_d;

  assign in_ready  = (st_q == IDLE);
  assign out_valid = (st_q == DONE);
  assign ret       = ret_q;
  assign cx        = c_q[0];
  assign cy        = c_q[1];
  assign cz        = c_q[2];
  assign normalx   = n_q[0];
  assign normaly   = n_q[1];
  assign normalz   = n_q[2];
  assign depth     = dep_q;

  // Arithmetic for every stage: squares, compare, one sqrt/div step, final multiply
  always_comb begin
    d2_d = '0; ea = '0;
    for (int i = 0; i < 3; i++) begin
      ea   = {{(DW-W-1){dif_q[i][W]}}, dif_q[i]};
      d2_d = d2_d + ea * ea;
    end
    er    = {{(PW-W-1){rsum_q[W]}}, rsum_q};
    rs2_d = er * er;
    rs2_x = {{(DW-PW){rs2_q[PW-1]}}, rs2_q};
    hit_d = (d2_q <= rs2_x);

    // sqrt: bring down the next two radicand bits, try (root<<2)|1
    rem_sh = (srem_q << 2) | RW'(d2_q[2*W+1 -: 2]);
    trial  = {1'b0, root_q, 2'b01};
    if (rem_sh >= trial) begin
      rem_nx  = rem_sh - trial;
      root_nx = (root_q << 1) | (W+1)'(1);
    end else begin
      rem_nx  = rem_sh;
      root_nx = root_q << 1;
    end
    root_sat = (root_nx[W] | root_nx[W-1]) ? SMAX : root_nx[W-1:0];

    // divide: bring down the next numerator bit below NUM_HI
    d_ext   = {1'b0, d_q};
    drem_sh = (drem_q << 1) | (W+1)'(nsh_q[W-1]);
    if (drem_sh >= d_ext) begin
      drem_nx = drem_sh - d_ext;
      quo_nx  = (quo_q << 1) | W'(1);
    end else begin
      drem_nx = drem_sh;
      quo_nx  = quo_q << 1;
    end
    // quotient overflows W bits when the part above them already reaches d
    ovf = (NUM_HI >= (2*W)'(d_q));
    inv = (ovf | quo_q[W-1]) ? SMAX : quo_q;

    // contact point sits halfway between the two surfaces along the normal
    kx = {{2{r2_q[W-1]}}, r2_q} - {{2{r1_q[W-1]}}, r1_q} - {2'b00, d_q};
    kk = kx >>> 1;
    a = '0; b = PW'(inv); pn = '0; en = '0; ek = '0; pc = '0;
    for (int i = 0; i < 3; i++) begin
      a         = {{(PW-W-1){dif_q[i][W]}}, dif_q[i]};
      pn        = a * b;
      nrm_d[i]  = W'(pn >>> FRAC);
      en        = {{(PW-W){nrm_d[i][W-1]}}, nrm_d[i]};
      ek        = {{(PW-W-2){kk[W+1]}}, kk};
      pc        = en * ek;
      cpos_d[i] = p1_q[i] + W'(pc >>> FRAC);
    end
    dep_d = W'(rsum_q - $signed({1'b0, d_q}));
  end

  // Request sequencer: next state
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE: if (in_valid) st_d = CALC;
      CALC: st_d = SQR;
      SQR:  st_d = CMP;
      CMP:  st_d = (EARLY_EXIT && !hit_q) ? DONE : SQRT;
      SQRT: if (cnt_q == CW'(W)) st_d = (EARLY_EXIT && root_nx == '0) ? MUL : DIV;
      DIV:  if (cnt_q == CW'(W-1)) st_d = MUL;
      MUL:  st_d = DONE;
      DONE: if (out_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  // Datapath registers, loaded according to the current stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        dif_q[i] <= '0; p1_q[i] <= '0; c_q[i] <= '0; n_q[i] <= '0;
      end
      rsum_q <= '0; r1_q <= '0; r2_q <= '0; d2_q <= '0; rs2_q <= '0;
      hit_q <= 1'b0; cnt_q <= '0; srem_q <= '0; root_q <= '0; d_q <= '0;
      drem_q <= '0; quo_q <= '0; nsh_q <= '0; ret_q <= 1'b0; dep_q <= '0;
    end else begin
      case (st_q)
        IDLE: if (in_valid) begin
          dif_q[0] <= $signed({x1[W-1], x1}) - $signed({x2[W-1], x2});
          dif_q[1] <= $signed({y1[W-1], y1}) - $signed({y2[W-1], y2});
          dif_q[2] <= $signed({z1[W-1], z1}) - $signed({z2[W-1], z2});
          rsum_q   <= $signed({r1[W-1], r1}) + $signed({r2[W-1], r2});
          p1_q[0] <= x1; p1_q[1] <= y1; p1_q[2] <= z1;
          r1_q <= r1; r2_q <= r2;
        end
        CALC: begin
          d2_q  <= d2_d;
          rs2_q <= rs2_d;
        end
        SQR: hit_q <= hit_d;
        CMP: begin
          cnt_q <= '0; srem_q <= '0; root_q <= '0;
          if (EARLY_EXIT && !hit_q) begin
            ret_q <= 1'b0; dep_q <= '0;
            for (int i = 0; i < 3; i++) begin c_q[i] <= '0; n_q[i] <= '0; end
          end
        end
        SQRT: begin
          srem_q <= rem_nx;
          root_q <= root_nx;
          d2_q   <= d2_q << 2;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(W)) begin
            cnt_q  <= '0;
            d_q    <= root_sat;
            drem_q <= (W+1)'(NUM_HI);
            quo_q  <= '0;
            nsh_q  <= NUM[W-1:0];
          end
        end
        DIV: begin
          drem_q <= drem_nx;
          quo_q  <= quo_nx;
          nsh_q  <= nsh_q << 1;
          cnt_q  <= cnt_q + 1'b1;
        end
        MUL: begin
          ret_q <= hit_q;
          if (!hit_q) begin
            dep_q <= '0;
            for (int i = 0; i < 3; i++) begin c_q[i] <= '0; n_q[i] <= '0; end
          end else if (d_q == '0) begin
            // coincident centres: fixed +x normal, contact at p1
            dep_q <= W'(rsum_q);
            n_q[0] <= ONE; n_q[1] <= '0; n_q[2] <= '0;
            for (int i = 0; i < 3; i++) c_q[i] <= p1_q[i];
          end else begin
            dep_q <= dep_d;
            for (int i = 0; i < 3; i++) begin c_q[i] <= cpos_d[i]; n_q[i] <= nrm_d[i]; end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dcollide_spheres_fx.sv
// Directed bench: two instances (early exit on / off) sharing data inputs.
module tb_dcollide_spheres_fx;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] x1, y1, z1, r1, x2, y2, z2, r2;
  } req_t;
  typedef struct packed {
    logic ret;
    logic [W-1:0] cx, cy, cz, nx, ny, nz, dp;
  } res_t;

  logic clk = 1'b0;
  logic rst, iv_a, iv_b, ordy;
  logic [W-1:0] x1, y1, z1, r1, x2, y2, z2, r2;
  logic rdy_a, rdy_b, ov_a, ov_b, ret_a, ret_b;
  logic [W-1:0] cx_a, cy_a, cz_a, nx_a, ny_a, nz_a, dp_a;
  logic [W-1:0] cx_b, cy_b, cz_b, nx_b, ny_b, nz_b, dp_b;
  res_t res_a, res_b;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  assign res_a = {ret_a, cx_a, cy_a, cz_a, nx_a, ny_a, nz_a, dp_a};
  assign res_b = {ret_b, cx_b, cy_b, cz_b, nx_b, ny_b, nz_b, dp_b};

  dcollide_spheres_fx #(.W(W), .FRAC(16), .EARLY_EXIT(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(rdy_a),
    .x1(x1), .y1(y1), .z1(z1), .r1(r1), .x2(x2), .y2(y2), .z2(z2), .r2(r2),
    .out_valid(ov_a), .out_ready(ordy), .ret(ret_a),
    .cx(cx_a), .cy(cy_a), .cz(cz_a),
    .normalx(nx_a), .normaly(ny_a), .normalz(nz_a), .depth(dp_a));

  dcollide_spheres_fx #(.W(W), .FRAC(16), .EARLY_EXIT(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(rdy_b),
    .x1(x1), .y1(y1), .z1(z1), .r1(r1), .x2(x2), .y2(y2), .z2(z2), .r2(r2),
    .out_valid(ov_b), .out_ready(ordy), .ret(ret_b),
    .cx(cx_b), .cy(cy_b), .cz(cz_b),
    .normalx(nx_b), .normaly(ny_b), .normalz(nz_b), .depth(dp_b));

  // hand-computed vectors (16 fraction bits)
  localparam req_t V1 = {32'h10000, 32'h0, 32'h0, 32'hC000, 32'h0, 32'h0, 32'h0, 32'hC000};
  localparam res_t E1 = {1'b1, 32'h8000, 32'h0, 32'h0, 32'h10000, 32'h0, 32'h0, 32'h8000};
  localparam req_t V2 = {32'h30000, 32'h0, 32'h0, 32'h8000, 32'h0, 32'h0, 32'h0, 32'h8000};
  localparam res_t E0 = {1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam req_t V3 = {32'h20000, 32'h20000, 32'h20000, 32'h8000,
                         32'h20000, 32'h20000, 32'h20000, 32'h8000};
  localparam res_t E3 = {1'b1, 32'h20000, 32'h20000, 32'h20000, 32'h10000, 32'h0, 32'h0, 32'h10000};
  localparam req_t V4 = {32'h10000, 32'h0, 32'h0, 32'h8000, 32'h0, 32'h0, 32'h0, 32'h8000};
  localparam res_t E4 = {1'b1, 32'h8000, 32'h0, 32'h0, 32'h10000, 32'h0, 32'h0, 32'h0};
  localparam req_t V5 = {32'h0, 32'h0, 32'h0, 32'h18000, 32'h0, 32'h20000, 32'h0, 32'h18000};
  localparam res_t E5 = {1'b1, 32'h0, 32'h10000, 32'h0, 32'h0, 32'hFFFF0000, 32'h0, 32'h10000};
  // d = isqrt(2^33) = 92681, inv = 2^32/92681 = 46341, k = -46341
  localparam req_t V6 = {32'h10000, 32'h10000, 32'h0, 32'h10000, 32'h0, 32'h0, 32'h0, 32'h10000};
  localparam res_t E6 = {1'b1, 32'h7FFF, 32'h7FFF, 32'h0, 32'hB505, 32'hB505, 32'h0, 32'h95F7};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input req_t q);
    {x1, y1, z1, r1, x2, y2, z2, r2} = q;
  endtask

  task automatic check_res(input string tag, input res_t got, input res_t exp);
    chk({tag, ".ret"},   got.ret, exp.ret);
    chk({tag, ".cx"},    got.cx,  exp.cx);
    chk({tag, ".cy"},    got.cy,  exp.cy);
    chk({tag, ".cz"},    got.cz,  exp.cz);
    chk({tag, ".nx"},    got.nx,  exp.nx);
    chk({tag, ".ny"},    got.ny,  exp.ny);
    chk({tag, ".nz"},    got.nz,  exp.nz);
    chk({tag, ".depth"}, got.dp,  exp.dp);
  endtask

  // present a request and return #1 after its accept edge
  task automatic send(input bit sel, input req_t q);
    int n;
    @(negedge clk);
    drive(q);
    if (sel) iv_b = 1'b1; else iv_a = 1'b1;
    n = 0;
    while (!(sel ? rdy_b : rdy_a) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    iv_a = 1'b0; iv_b = 1'b0;
  endtask

  // edges from the accept edge until out_valid is seen
  task automatic wait_out(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? ov_b : ov_a) && lat < 300) begin @(posedge clk); lat++; #1; end
  endtask

  task automatic run(input string tag, input bit sel, input req_t q, input res_t e, input int elat);
    int lat;
    send(sel, q);
    wait_out(sel, lat);
    chk({tag, ".lat"}, lat, elat);
    check_res(tag, sel ? res_b : res_a, e);
    @(posedge clk); #1;   // out_ready is high: handshake
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b1; iv_a = 1'b0; iv_b = 1'b0; ordy = 1'b1;
    drive('0);
    repeat (2) @(posedge clk); #1;
    chk("rst.in_ready", rdy_a, 1);
    chk("rst.out_valid", ov_a, 0);
    check_res("rst", res_a, E0);
    @(negedge clk); rst = 1'b0;

    run("t1a", 0, V1, E1, 69);
    run("t1b", 1, V1, E1, 69);
    run("t2a", 0, V2, E0, 3);
    run("t2b", 1, V2, E0, 69);
    run("t3a", 0, V3, E3, 37);
    run("t3b", 1, V3, E3, 69);
    run("t4a", 0, V4, E4, 69);
    run("t5a", 0, V5, E5, 69);
    run("t6a", 0, V6, E6, 69);
    run("t6b", 1, V6, E6, 69);

    // back-pressure with a second request waiting
    @(negedge clk); drive(V1); iv_a = 1'b1; ordy = 1'b0;
    @(posedge clk); #1; drive(V5);
    wait_out(0, lat);
    chk("bp.lat", lat, 69);
    repeat (10) @(posedge clk); #1;
    chk("bp.out_valid", ov_a, 1);
    chk("bp.in_ready", rdy_a, 0);
    check_res("bp", res_a, E1);
    @(negedge clk); ordy = 1'b1;
    @(posedge clk); #1;
    chk("bp.ov_drop", ov_a, 0);
    chk("bp.in_ready_up", rdy_a, 1);
    @(posedge clk); #1; iv_a = 1'b0;   // second request taken on this edge
    wait_out(0, lat);
    chk("bp2.lat", lat, 69);
    check_res("bp2", res_a, E5);
    @(posedge clk); #1;

    // reset in the middle of the sqrt phase
    send(0, V6);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid.out_valid", ov_a, 0);
    chk("mid.in_ready", rdy_a, 1);
    chk("mid.cy", cy_a, 0);
    chk("mid.depth", dp_a, 0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (ov_a) seen = 1'b1; end
    chk("mid.no_stale", seen, 0);
    run("mid.after", 0, V6, E6, 69);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
